// File: rtl/mil1553_pkg.sv
// Shared MIL-STD-1553B word-format constants, bus level encoding and parity helpers
// used by both the transmit encoder and the receive-side timing logic.
package mil1553_pkg;

  localparam int SYNC_HALF_BITS = 3;
  localparam int WORD_HALF_BITS = 40;
  localparam int DATA_BITS      = 16;

  typedef enum logic {
    SYNC_CMD  = 1'b0,
    SYNC_DATA = 1'b1
  } sync_e;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_TX   = 1'b1;

  // Bus level is {tx_p, tx_n}; the both-high code is never produced.
  typedef logic [1:0] bus_lvl_t;
  localparam bus_lvl_t BUS_IDLE = 2'b00;
  localparam bus_lvl_t BUS_HIGH = 2'b10;
  localparam bus_lvl_t BUS_LOW  = 2'b01;

  function automatic logic odd_parity(input logic [DATA_BITS-1:0] data);
    return ~^data;
  endfunction

  // Manchester II: a one is HIGH then LOW, a zero is LOW then HIGH.
  function automatic bus_lvl_t bit_half_level(input logic bit_val, input logic second_half);
    return (bit_val ^ second_half) ? BUS_HIGH : BUS_LOW;
  endfunction

endpackage

// File: rtl/mil1553_halfbit_timer.sv
// Half-bit clock counter: wraps every HALF_BIT_CLKS cycles while running and flags
// the final cycle of each half-bit; also shared by the receiver's sample timing.
module mil1553_halfbit_timer #(
  parameter int HALF_BIT_CLKS = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic run_i,
  output logic end_o,
  output logic last_next_o
);

  localparam int CNT_W = (HALF_BIT_CLKS > 1) ? $clog2(HALF_BIT_CLKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_BIT_CLKS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign end_o = run_i && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = end_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Lets the owner register a strobe aligned with the last cycle of the next half-bit.
  assign last_next_o = (cnt_d == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mil1553_tx_encoder.sv
// MIL-STD-1553B Manchester II word transmitter: sync + 16 data bits (MSB first)
// + odd parity, one word per valid/ready transfer, with back-to-back chaining.
module mil1553_tx_encoder
  import mil1553_pkg::*;
#(
  parameter int HALF_BIT_CLKS = 25,
  parameter int IDLE_GAP_CLKS = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        word_valid,
  output logic        word_ready,
  input  logic [15:0] word_data,
  input  logic        word_is_data,
  input  logic        tx_abort,
  output logic        tx_p,
  output logic        tx_n,
  output logic        tx_en,
  output logic        busy,
  output logic        word_done
);

  localparam int GAP_W = (IDLE_GAP_CLKS > 0) ? $clog2(IDLE_GAP_CLKS + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IDLE_GAP_CLKS);
  localparam logic [5:0] H_LAST  = 6'(WORD_HALF_BITS - 1);
  localparam logic [5:0] H_SYNC2 = 6'(SYNC_HALF_BITS);
  localparam logic [5:0] H_DATA0 = 6'(2 * SYNC_HALF_BITS);
  localparam int SH_W = DATA_BITS + 1;

  state_t           state_q, state_d;
  logic [5:0]       h_q, h_d;
  logic [SH_W-1:0]  sh_q, sh_d;
  sync_e            sync_q, sync_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  bus_lvl_t         lvl_q, lvl_d;
  logic             en_q, en_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             aborted;
  logic             xfer;
  logic             half_end;
  logic             last_next;
  logic             tmr_clear;
  logic             tmr_run;

  function automatic bus_lvl_t level_at(input state_t st, input logic [5:0] h,
                                        input logic msb, input sync_e sy);
    if (st == ST_IDLE) return BUS_IDLE;
    if (h < H_SYNC2)   return (sy == SYNC_DATA) ? BUS_LOW : BUS_HIGH;
    if (h < H_DATA0)   return (sy == SYNC_DATA) ? BUS_HIGH : BUS_LOW;
    return bit_half_level(msb, h[0]);
  endfunction

  assign tmr_run = (state_q == ST_TX);

  mil1553_halfbit_timer #(
    .HALF_BIT_CLKS(HALF_BIT_CLKS)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (tmr_clear),
    .run_i      (tmr_run),
    .end_o      (half_end),
    .last_next_o(last_next)
  );

  assign xfer = word_valid && ready_q;

  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    sh_d      = sh_q;
    sync_d    = sync_q;
    gap_d     = gap_q;
    done_d    = 1'b0;
    aborted   = 1'b0;
    tmr_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gap_q != '0) gap_d = gap_q - GAP_W'(1);
        if (xfer) begin
          state_d   = ST_TX;
          h_d       = '0;
          sh_d      = {word_data, odd_parity(word_data)};
          sync_d    = sync_e'(word_is_data);
          tmr_clear = 1'b1;
        end
      end
      default: begin
        // Abort wins even over a transfer offered in the final cycle of h39.
        if (tx_abort) begin
          state_d   = ST_IDLE;
          h_d       = '0;
          gap_d     = GAP_LOAD;
          aborted   = 1'b1;
          tmr_clear = 1'b1;
        end else if (half_end) begin
          if (h_q == H_LAST) begin
            done_d = 1'b1;
            h_d    = '0;
            if (xfer) begin
              sh_d      = {word_data, odd_parity(word_data)};
              sync_d    = sync_e'(word_is_data);
              tmr_clear = 1'b1;
            end else begin
              state_d = ST_IDLE;
              gap_d   = GAP_LOAD;
            end
          end else begin
            h_d = h_q + 6'd1;
            if (h_q[0] && (h_q > H_DATA0)) sh_d = {sh_q[SH_W-2:0], 1'b0};
          end
        end
      end
    endcase

    lvl_d   = level_at(state_d, h_d, sh_d[SH_W-1], sync_d);
    en_d    = (state_d == ST_TX);
    ready_d = (state_d == ST_TX) ? ((h_d == H_LAST) && last_next)
                                 : ((gap_d == '0) && !aborted);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      gap_q   <= '0;
      lvl_q   <= BUS_IDLE;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      gap_q   <= gap_d;
      lvl_q   <= lvl_d;
      en_q    <= en_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    sh_q   <= sh_d;
    sync_q <= sync_d;
  end

  assign tx_p       = lvl_q[1];
  assign tx_n       = lvl_q[0];
  assign tx_en      = en_q;
  assign busy       = en_q;
  assign word_done  = done_q;
  assign word_ready = ready_q;

endmodule

// File: tb/tb_mil1553_tx_encoder.sv
// Bench for mil1553_tx_encoder: directed scenarios plus random traffic, every cycle
// compared against a queue of expected bus levels built from the word-format rules.
module tb_mil1553_tx_encoder;

  localparam int HB        = 4;
  localparam int GAP       = 8;
  localparam int WORD_CLKS = 40 * HB;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        word_valid;
  logic        word_ready;
  logic [15:0] word_data;
  logic        word_is_data;
  logic        tx_abort;
  logic        tx_p, tx_n, tx_en, busy, word_done;

  always #5 clk = ~clk;

  mil1553_tx_encoder #(
    .HALF_BIT_CLKS(HB),
    .IDLE_GAP_CLKS(GAP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .word_data   (word_data),
    .word_is_data(word_is_data),
    .tx_abort    (tx_abort),
    .tx_p        (tx_p),
    .tx_n        (tx_n),
    .tx_en       (tx_en),
    .busy        (busy),
    .word_done   (word_done)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one {p,n} entry per clock still to be driven for accepted words.
  logic [1:0] lv_q[$];
  int         gap_m    = 0;
  bit         force_nr = 1'b0;
  bit         done_m   = 1'b0;
  bit         cmp_on   = 1'b0;
  int         en_run   = 0;
  int         last_run = 0;
  int         idle_run = 0;
  int         last_gap = 0;

  function automatic logic model_ready();
    if (lv_q.size() > 0) return (lv_q.size() == 1);
    return (gap_m == 0) && !force_nr;
  endfunction

  task automatic push_word(input logic [15:0] d, input logic isd);
    logic [1:0] hi;
    logic [1:0] lo;
    logic [1:0] halves [40];
    logic       par;
    logic       b;
    int         ones;
    hi   = 2'b10;
    lo   = 2'b01;
    ones = 0;
    for (int k = 0; k < 16; k++) ones += int'(d[k]);
    par = ((ones % 2) == 0);
    for (int h = 0; h < 3; h++) halves[h] = isd ? lo : hi;
    for (int h = 3; h < 6; h++) halves[h] = isd ? hi : lo;
    for (int i = 0; i < 17; i++) begin
      b = (i < 16) ? d[15-i] : par;
      halves[6+2*i] = b ? hi : lo;
      halves[7+2*i] = b ? lo : hi;
    end
    for (int h = 0; h < 40; h++)
      for (int c = 0; c < HB; c++) lv_q.push_back(halves[h]);
  endtask

  task automatic cycle(input logic v, input logic [15:0] d, input logic isd,
                       input logic ab, input logic rn);
    logic [1:0] e;
    logic       xfer;
    if (cmp_on) begin
      e = (lv_q.size() > 0) ? lv_q[0] : 2'b00;
      check("tx_p", 32'(tx_p), 32'(e[1]));
      check("tx_n", 32'(tx_n), 32'(e[0]));
      check("tx_en", 32'(tx_en), 32'(lv_q.size() > 0));
      check("busy", 32'(busy), 32'(lv_q.size() > 0));
      check("word_done", 32'(word_done), 32'(done_m));
      check("word_ready", 32'(word_ready), 32'(model_ready()));
      if (tx_en === 1'b1) begin
        if (en_run == 0) last_gap = idle_run;
        en_run++;
        idle_run = 0;
      end else begin
        if (en_run > 0) last_run = en_run;
        en_run = 0;
        idle_run++;
      end
    end
    rst_n        = rn;
    word_valid   = v;
    word_data    = d;
    word_is_data = isd;
    tx_abort     = ab;
    xfer = v && model_ready();
    if (!rn) begin
      lv_q.delete();
      gap_m = 0; force_nr = 1'b0; done_m = 1'b0;
    end else if (ab && lv_q.size() > 0) begin
      lv_q.delete();
      gap_m = GAP; force_nr = 1'b1; done_m = 1'b0;
    end else begin
      force_nr = 1'b0;
      done_m   = 1'b0;
      if (lv_q.size() > 0) begin
        void'(lv_q.pop_front());
        if (lv_q.size() == 0) begin
          done_m = 1'b1;
          gap_m  = GAP;
        end
      end else if (gap_m > 0) begin
        gap_m--;
      end
      if (xfer) push_word(d, isd);
    end
    @(posedge clk);
    @(negedge clk);
    cmp_on = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic send(input logic [15:0] d, input logic isd);
    int n;
    bit took;
    n = 0;
    took = 1'b0;
    while (!took && n < 400) begin
      took = model_ready();
      cycle(1'b1, d, isd, 1'b0, 1'b1);
      n++;
    end
    if (!took) check("send_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    rst_n = 1'b0; word_valid = 1'b0; word_data = '0; word_is_data = 1'b0; tx_abort = 1'b0;
    @(negedge clk);
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    idle(2);
    check("rst_ready", 32'(word_ready), 32'(1));
    check("rst_en", 32'(tx_en), 32'(0));

    send(16'h0000, 1'b0);
    idle(WORD_CLKS + 2);
    check("len_0000", 32'(last_run), 32'(WORD_CLKS));

    send(16'hFFFF, 1'b1);
    idle(38 * HB);
    check("par_ffff_p", 32'(tx_p), 32'(1));
    check("par_ffff_n", 32'(tx_n), 32'(0));
    idle(2 * HB + GAP + 2);

    send(16'hA5A5, 1'b0);
    send(16'h1234, 1'b1);
    idle(WORD_CLKS + 2);
    check("len_b2b", 32'(last_run), 32'(2 * WORD_CLKS));
    idle(GAP);

    send(16'h8001, 1'b0);
    idle(10 * HB);
    cycle(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
    check("abort_en", 32'(tx_en), 32'(0));
    check("abort_done", 32'(word_done), 32'(0));
    check("abort_ready", 32'(word_ready), 32'(0));
    idle(GAP + 2);

    send(16'h5555, 1'b1);
    idle(20 * HB);
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    check("midrst_en", 32'(tx_en), 32'(0));
    check("midrst_ready", 32'(word_ready), 32'(1));
    send(16'h0001, 1'b0);
    idle(WORD_CLKS + 1);
    idle(GAP);

    send(16'h0F0F, 1'b1);
    idle(WORD_CLKS);
    send(16'hF0F0, 1'b0);
    idle(1);
    check("gap_min", 32'(last_gap >= GAP), 32'(1));
    idle(WORD_CLKS + GAP + 2);

    for (int it = 0; it < 40; it++) begin
      send(16'($urandom), 1'($urandom_range(0, 1)));
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        idle(int'($urandom_range(0, WORD_CLKS - 2)));
        cycle(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
      end else if (r == 1) begin
        idle(int'($urandom_range(0, WORD_CLKS - 2)));
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      end else begin
        idle(int'($urandom_range(0, WORD_CLKS + 20)));
      end
    end
    idle(WORD_CLKS + GAP + 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
